if_fetch_resp: RTL and testbench

//  Instruction-fetch responder. It is the memory-side end of the PC generator's

---
 rtl/if_fetch_resp.sv | 233 +++++++++++++++++++++++
 tb/tb_if_fetch_resp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_resp.sv
// -----------------------------------------------------------------------------
// if_fetch_resp
//   Memory-side end of the PC generator's fetch interface. Takes ce/pc, issues
//   a single outstanding read on the instruction bus and returns the
//   instruction and its address to the IF/ID register. While a fetch is in
//   progress it requests a PC hold, so the PC only advances on the edge that
//   registers the fetched instruction. A flush (jump or interrupt) aborts or
//   discards the fetch that is in flight.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   ce_i, pc_i             fetch enable and word-aligned fetch address
//   stall_i[5:0]           pipeline stall vector, bit 1 holds IF/ID
//   flush_i                single-cycle jump/interrupt flush
//   stallreq_o             PC hold request (combinational)
//   bus_req_o/bus_addr_o   read request and address, held until granted
//   bus_gnt_i              request accepted this cycle
//   bus_rvalid_i/rdata_i   read data return, bus_err_i qualified by rvalid
//   inst_o/inst_addr_o     fetched instruction and its address
//   inst_valid_o           inst_o holds a valid instruction
//   fetch_fault_o          one-cycle pulse marking a faulted (NOP) delivery
// -----------------------------------------------------------------------------
module if_fetch_resp #(
   parameter int ADDR_WIDTH     = 32,
   parameter int INST_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  ce_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [5:0]            stall_i,
   input  logic                  flush_i,
   output logic                  stallreq_o,
   output logic                  bus_req_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [INST_WIDTH-1:0] bus_rdata_i,
   input  logic                  bus_err_i,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_addr_o,
   output logic                  inst_valid_o,
   output logic                  fetch_fault_o
);

   localparam logic                  STOP     = 1'b1;
   localparam logic [INST_WIDTH-1:0] NOP      = INST_WIDTH'(32'h0000_0013);
   localparam int                    CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]      TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_e;

   // Counter saturates on its last value; the timeout condition stays true
   // until the fetch leaves REQ/WAIT, so a stalled timeout fires later.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      sat_inc = (cnt == TMO_LAST) ? cnt : cnt + CNT_W'(1);
   endfunction

   // A faulted delivery always presents a NOP instead of the bus data.
   function automatic logic [INST_WIDTH-1:0] fault_mask(input logic [INST_WIDTH-1:0] data,
                                                        input logic                  err);
      fault_mask = err ? NOP : data;
   endfunction

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic                    flush_seen_q, flush_seen_d;
   logic                    req_pend_q, req_pend_d;
   logic [INST_WIDTH-1:0]   skid_data_q;
   logic                    skid_err_q;

   logic                    hold_ok;
   logic                    tmo_hit;
   logic                    flush_now;
   logic                    deliver;
   logic [INST_WIDTH-1:0]   del_data;
   logic                    del_err;
   logic                    skid_load;
   logic                    latch_pc;
   logic                    cnt_clr;
   logic                    cnt_inc;

   // Only bit 1 of the stall vector concerns this stage.
   logic                    unused_stall;
   assign unused_stall = ^{stall_i[5:2], stall_i[0]};

   assign hold_ok   = (stall_i[1] != STOP);
   assign tmo_hit   = (cnt_q == TMO_LAST);
   assign flush_now = flush_i | flush_seen_q;

   // ---- next-state / delivery decision ----
   always_comb begin
      state_d      = state_q;
      flush_seen_d = flush_seen_q;
      req_pend_d   = req_pend_q;
      deliver      = 1'b0;
      del_data     = bus_rdata_i;
      del_err      = bus_err_i;
      skid_load    = 1'b0;
      latch_pc     = 1'b0;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;

      case (state_q)
         S_IDLE: begin
            flush_seen_d = 1'b0;
            req_pend_d   = 1'b0;
            if (ce_i && !flush_i) begin
               latch_pc = 1'b1;
               cnt_clr  = 1'b1;
               state_d  = S_REQ;
            end
         end

         S_REQ: begin
            cnt_inc = 1'b1;
            if (flush_i) flush_seen_d = 1'b1;
            // The request is never withdrawn: a flushed fetch still waits for
            // its grant and then discards the returning data in DROP.
            if (bus_gnt_i) state_d = flush_now ? S_DROP : S_WAIT;
            if (tmo_hit && !flush_now && hold_ok) begin
               deliver    = 1'b1;
               del_err    = 1'b1;
               state_d    = S_DROP;
               req_pend_d = !bus_gnt_i;
            end
         end

         S_WAIT: begin
            cnt_inc = 1'b1;
            if (flush_i) begin
               state_d = bus_rvalid_i ? S_IDLE : S_DROP;
            end else if (bus_rvalid_i) begin
               if (hold_ok) begin
                  deliver = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  skid_load = 1'b1;
                  state_d   = S_HOLD;
               end
            end else if (tmo_hit && hold_ok) begin
               deliver = 1'b1;
               del_err = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_HOLD: begin
            del_data = skid_data_q;
            del_err  = skid_err_q;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (hold_ok) begin
               deliver = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_DROP: begin
            // A timed-out request still owes the bus its grant before the
            // read it started can be drained.
            if (req_pend_q) begin
               if (bus_gnt_i) req_pend_d = 1'b0;
            end else if (bus_rvalid_i) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign stallreq_o = ce_i & ~deliver;
   assign bus_req_o  = (state_q == S_REQ) | ((state_q == S_DROP) & req_pend_q);

   // ---- control and output registers ----
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         flush_seen_q  <= 1'b0;
         req_pend_q    <= 1'b0;
         skid_err_q    <= 1'b0;
         bus_addr_o    <= '0;
         inst_o        <= NOP;
         inst_addr_o   <= '0;
         inst_valid_o  <= 1'b0;
         fetch_fault_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_seen_q <= flush_seen_d;
         req_pend_q   <= req_pend_d;

         if (cnt_clr)      cnt_q <= '0;
         else if (cnt_inc) cnt_q <= sat_inc(cnt_q);

         if (latch_pc)  bus_addr_o <= pc_i;
         if (skid_load) skid_err_q <= bus_err_i;

         // Flush beats delivery and stall; a stall freezes IF/ID but the
         // fault flag stays a single-cycle pulse.
         if (flush_i) begin
            inst_valid_o  <= 1'b0;
            inst_o        <= NOP;
            fetch_fault_o <= 1'b0;
         end else if (deliver) begin
            inst_o        <= fault_mask(del_data, del_err);
            inst_addr_o   <= bus_addr_o;
            inst_valid_o  <= 1'b1;
            fetch_fault_o <= del_err;
         end else if (!hold_ok) begin
            fetch_fault_o <= 1'b0;
         end else begin
            inst_valid_o  <= 1'b0;
            inst_o        <= NOP;
            fetch_fault_o <= 1'b0;
         end
      end
   end

   // ---- skid data register ----
   always_ff @(posedge clk_i) begin
      if (skid_load) skid_data_q <= bus_rdata_i;
   end

endmodule

// File: tb/tb_if_fetch_resp.sv
module tb_if_fetch_resp;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic [31:0] pc;
   logic [5:0]  stall;
   logic        flush;
   logic        stallreq;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] inst;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic        fault;

   int n_pass = 0;
   int n_fail = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   if_fetch_resp #(
      .ADDR_WIDTH    (32),
      .INST_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .ce_i         (ce),
      .pc_i         (pc),
      .stall_i      (stall),
      .flush_i      (flush),
      .stallreq_o   (stallreq),
      .bus_req_o    (bus_req),
      .bus_addr_o   (bus_addr),
      .bus_gnt_i    (gnt),
      .bus_rvalid_i (rvalid),
      .bus_rdata_i  (rdata),
      .bus_err_i    (err),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr),
      .inst_valid_o (inst_valid),
      .fetch_fault_o(fault)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: models the PC generator, which advances pc by 4 on any edge
   // where fetch is enabled and no hold is requested.
   task automatic cyc();
      logic adv;
      #1;
      adv = ce & ~stallreq & rst_n;
      @(posedge clk);
      #1;
      if (adv) pc = pc + 32'd4;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; pc = 32'h0; stall = 6'b0; flush = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; err = 1'b0;
      @(negedge clk);
      cyc(); cyc();

      // reset state
      #1;
      chk("rst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, NOP);
      chk("rst_iaddr", inst_addr, 32'h0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_busreq", bus_req, 1'b0);
      chk("rst_busaddr", bus_addr, 32'h0);
      chk("rst_stallreq", stallreq, 1'b0);

      // 1: zero-wait fetches of 0x0, 0x4, 0x8
      rst_n = 1'b1; ce = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t1_stallreq_idle", stallreq, 1'b1);
         cyc();
         #1;
         chk("t1_busreq", bus_req, 1'b1);
         chk("t1_busaddr", bus_addr, 32'(4 * k));
         chk("t1_valid_gap", inst_valid, 1'b0);
         gnt = 1'b1; cyc(); gnt = 1'b0;
         rvalid = 1'b1; rdata = 32'h1000_0000 + 32'(k);
         #1 chk("t1_stallreq_deliver", stallreq, 1'b0);
         cyc(); rvalid = 1'b0;
         #1;
         chk("t1_valid", inst_valid, 1'b1);
         chk("t1_inst", inst, 32'h1000_0000 + 32'(k));
         chk("t1_iaddr", inst_addr, 32'(4 * k));
         chk("t1_fault", fault, 1'b0);
      end
      chk("t1_pc", pc, 32'hC);

      // 2: grant two cycles late, rvalid three cycles after grant
      cyc();
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("t2_busaddr", bus_addr, 32'hC);
         chk("t2_busreq", bus_req, 1'b1);
         chk("t2_stallreq", stallreq, 1'b1);
         cyc();
      end
      gnt = 1'b1;
      #1 chk("t2_busaddr_gnt", bus_addr, 32'hC);
      cyc(); gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1 chk("t2_stallreq_wait", stallreq, 1'b1);
         cyc();
      end
      rvalid = 1'b1; rdata = 32'h2222_0000;
      #1 chk("t2_stallreq_deliver", stallreq, 1'b0);
      cyc(); rvalid = 1'b0;
      #1;
      chk("t2_inst", inst, 32'h2222_0000);
      chk("t2_iaddr", inst_addr, 32'hC);
      chk("t2_pc_once", pc, 32'h10);

      // 3: flush in WAIT, stale 0xDEADBEEF arrives in DROP, refetch 0x100
      cyc();
      gnt = 1'b1; cyc(); gnt = 1'b0;
      flush = 1'b1; pc = 32'h100;
      #1 chk("t3_stallreq_flush", stallreq, 1'b1);
      cyc(); flush = 1'b0;
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      #1;
      chk("t3_busreq_drop", bus_req, 1'b0);
      chk("t3_valid_drop", inst_valid, 1'b0);
      chk("t3_stallreq_drop", stallreq, 1'b1);
      cyc(); rvalid = 1'b0;
      #1;
      chk("t3_valid_discard", inst_valid, 1'b0);
      chk("t3_inst_discard", inst, NOP);
      cyc();
      #1;
      chk("t3_busreq_new", bus_req, 1'b1);
      chk("t3_busaddr_new", bus_addr, 32'h100);
      gnt = 1'b1; cyc(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h3333_0000;
      cyc(); rvalid = 1'b0;
      #1;
      chk("t3_inst", inst, 32'h3333_0000);
      chk("t3_iaddr", inst_addr, 32'h100);

      // 4: IF/ID stalled for 4 cycles while the next read returns
      stall = 6'b000010;
      cyc();
      #1;
      chk("t4_hold_inst", inst, 32'h3333_0000);
      chk("t4_hold_valid", inst_valid, 1'b1);
      gnt = 1'b1; cyc(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h4444_0000;
      #1 chk("t4_stallreq_skid", stallreq, 1'b1);
      cyc(); rvalid = 1'b0;
      #1;
      chk("t4_hold_inst2", inst, 32'h3333_0000);
      chk("t4_stallreq_hold", stallreq, 1'b1);
      cyc();
      stall = 6'b0;
      #1;
      chk("t4_hold_inst3", inst, 32'h3333_0000);
      chk("t4_stallreq_release", stallreq, 1'b0);
      cyc();
      #1;
      chk("t4_inst", inst, 32'h4444_0000);
      chk("t4_iaddr", inst_addr, 32'h104);
      chk("t4_valid", inst_valid, 1'b1);
      chk("t4_pc", pc, 32'h108);

      // 5a: no rvalid -> timeout after 8 cycles in REQ+WAIT
      cyc();
      gnt = 1'b1; cyc(); gnt = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1 chk("t5_stallreq_wait", stallreq, 1'b1);
         cyc();
      end
      #1 chk("t5_stallreq_tmo", stallreq, 1'b0);
      cyc(); ce = 1'b0;
      #1;
      chk("t5_tmo_inst", inst, NOP);
      chk("t5_tmo_valid", inst_valid, 1'b1);
      chk("t5_tmo_fault", fault, 1'b1);
      chk("t5_tmo_iaddr", inst_addr, 32'h108);
      cyc();
      #1;
      chk("t5_tmo_pulse", fault, 1'b0);
      chk("t5_tmo_valid_clr", inst_valid, 1'b0);

      // 5b: bus error returned with rvalid
      ce = 1'b1;
      cyc();
      gnt = 1'b1; cyc(); gnt = 1'b0;
      rvalid = 1'b1; err = 1'b1; rdata = 32'hFFFF_FFFF;
      #1 chk("t5_stallreq_err", stallreq, 1'b0);
      cyc(); rvalid = 1'b0; err = 1'b0; ce = 1'b0;
      #1;
      chk("t5_err_inst", inst, NOP);
      chk("t5_err_fault", fault, 1'b1);
      chk("t5_err_valid", inst_valid, 1'b1);
      chk("t5_err_iaddr", inst_addr, 32'h10C);
      cyc();
      #1 chk("t5_err_pulse", fault, 1'b0);

      // 5c: grant never arrives -> fault, request held until granted
      ce = 1'b1;
      cyc();
      for (int i = 0; i < 7; i++) cyc();
      #1 chk("t5c_stallreq_tmo", stallreq, 1'b0);
      cyc(); ce = 1'b0;
      #1;
      chk("t5c_fault", fault, 1'b1);
      chk("t5c_inst", inst, NOP);
      chk("t5c_iaddr", inst_addr, 32'h110);
      chk("t5c_busreq_pend", bus_req, 1'b1);
      gnt = 1'b1; cyc(); gnt = 1'b0;
      #1 chk("t5c_busreq_done", bus_req, 1'b0);
      rvalid = 1'b1; rdata = 32'h5555_0000;
      cyc(); rvalid = 1'b0;
      #1;
      chk("t5c_drop_valid", inst_valid, 1'b0);
      chk("t5c_drop_inst", inst, NOP);

      // 6: reset during WAIT, late rvalid after release
      ce = 1'b1;
      cyc();
      gnt = 1'b1; cyc(); gnt = 1'b0;
      rst_n = 1'b0;
      cyc();
      #1;
      chk("t6_busreq", bus_req, 1'b0);
      chk("t6_busaddr", bus_addr, 32'h0);
      chk("t6_iaddr", inst_addr, 32'h0);
      chk("t6_valid", inst_valid, 1'b0);
      chk("t6_inst", inst, NOP);
      rst_n = 1'b1;
      rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
      #1 chk("t6_stallreq_late", stallreq, 1'b1);
      cyc(); rvalid = 1'b0;
      #1;
      chk("t6_late_valid", inst_valid, 1'b0);
      chk("t6_late_inst", inst, NOP);
      chk("t6_refetch_req", bus_req, 1'b1);
      chk("t6_refetch_addr", bus_addr, 32'h114);
      gnt = 1'b1; cyc(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 32'h6666_0000;
      cyc(); rvalid = 1'b0;
      #1;
      chk("t6_inst", inst, 32'h6666_0000);
      chk("t6_iaddr", inst_addr, 32'h114);
      chk("t6_valid_new", inst_valid, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
